// File: rtl/tri_bus_arbiter_if.sv
// Bus-side signal bundle for tri_bus_arbiter: requester handshake in,
// grant/enable/status out. The arbiter takes the master view; requesters
// and the driver enables they feed take the slave view.
interface tri_bus_arbiter_if #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
);

  logic [N-1:0]  req;      // level request per driver
  logic [N-1:0]  done;     // release pulse per driver
  logic [N-1:0]  grant;    // one-hot owner select (GRANT and DRIVE)
  logic [N-1:0]  en;       // one-hot tristate driver enable (DRIVE only)
  logic [IW-1:0] owner;    // index of current or last owner
  logic          busy;     // high in GRANT, DRIVE and TURN
  logic          timeout;  // one-cycle pulse on a forced release

  // Arbiter side: samples requests, drives grants and enables.
  modport master (
    input  req,
    input  done,
    output grant,
    output en,
    output owner,
    output busy,
    output timeout
  );

  // Requester side: raises requests and releases, observes ownership.
  modport slave (
    output req,
    output done,
    input  grant,
    input  en,
    input  owner,
    input  busy,
    input  timeout
  );

endinterface

// File: rtl/tri_bus_arbiter.sv
// Round-robin arbiter and sequencer for a shared tristate/wired-logic net.
// Grants the net to one requester at a time, drives only that requester's
// enable, and inserts a TURN + GRANT all-off gap between owners so no two
// enables can overlap. Each grant is capped at MAX_HOLD drive cycles.
module tri_bus_arbiter #(
  parameter int N        = 4,
  parameter int MAX_HOLD = 8,
  parameter int IW       = $clog2(N)
) (
  input  logic              clk,
  input  logic              rst_n,
  tri_bus_arbiter_if.master bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    DRIVE = 2'd2,
    TURN  = 2'd3
  } state_t;

  localparam logic [7:0]    HOLD_LIMIT = 8'(MAX_HOLD);
  localparam logic [IW-1:0] LAST_IDX   = IW'(N - 1);

  state_t        state;
  logic [IW-1:0] ptr;         // first index searched by the next arbitration
  logic [7:0]    hold_cnt;    // drive cycles spent in the current grant

  logic [N-1:0]  grant_q;
  logic [N-1:0]  en_q;
  logic [IW-1:0] owner_q;
  logic          busy_q;
  logic          timeout_q;

  logic          pick_valid;
  logic [IW-1:0] pick_idx;
  logic [IW-1:0] pick_next;
  logic [IW-1:0] scan_idx;
  logic          owner_req;
  logic          owner_done;

  // Expand an owner index into a one-hot vector.
  function automatic logic [N-1:0] to_onehot(input logic [IW-1:0] idx);
    logic [N-1:0] vec;
    vec      = '0;
    vec[idx] = 1'b1;
    return vec;
  endfunction

  // Round-robin search: first set request at or after ptr, wrapping mod N.
  // Scanning from the far end lets the closest candidate overwrite the rest.
  always_comb begin
    // NOTE: every variable gets a default before any conditional write, so
    // no path leaves a value unassigned and no latch is inferred.
    pick_valid = 1'b0;
    pick_idx   = '0;
    scan_idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      scan_idx = IW'((int'(ptr) + i) % N);
      if (bus.req[scan_idx]) begin
        pick_valid = 1'b1;
        pick_idx   = scan_idx;
      end
    end
    pick_next = (pick_idx == LAST_IDX) ? '0 : pick_idx + 1'b1;
  end

  // Only the owner's request and release are ever looked at.
  always_comb begin
    owner_req  = bus.req[owner_q];
    owner_done = bus.done[owner_q];
  end

  // Sequencer: IDLE -> GRANT -> DRIVE -> TURN, all outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the arbitration pointer and hold counter are reset together
      // with the state so the first grant after reset always searches from 0.
      state     <= IDLE;
      ptr       <= '0;
      hold_cnt  <= '0;
      grant_q   <= '0;
      en_q      <= '0;
      owner_q   <= '0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every branch sees the
      // pre-edge values and later defaults are cleanly overridden.
      timeout_q <= 1'b0;

      unique case (state)
        IDLE: begin
          if (pick_valid) begin
            state   <= GRANT;
            grant_q <= to_onehot(pick_idx);
            owner_q <= pick_idx;
            ptr     <= pick_next;
            busy_q  <= 1'b1;
          end
        end

        // One setup cycle with the enable still off.
        GRANT: begin
          if (owner_req) begin
            state    <= DRIVE;
            en_q     <= grant_q;
            hold_cnt <= 8'd1;
          end else begin
            state   <= TURN;
            grant_q <= '0;
            en_q    <= '0;
          end
        end

        // Release on done or abandon; otherwise force release at the cap.
        // done is checked first so it beats a coinciding hold limit.
        DRIVE: begin
          if (owner_done || !owner_req) begin
            state   <= TURN;
            grant_q <= '0;
            en_q    <= '0;
          end else if (hold_cnt == HOLD_LIMIT) begin
            state     <= TURN;
            grant_q   <= '0;
            en_q      <= '0;
            timeout_q <= 1'b1;
          end else begin
            hold_cnt <= hold_cnt + 8'd1;
          end
        end

        // Guaranteed all-off cycle; re-arbitrate straight into GRANT.
        TURN: begin
          if (pick_valid) begin
            state   <= GRANT;
            grant_q <= to_onehot(pick_idx);
            owner_q <= pick_idx;
            ptr     <= pick_next;
          end else begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end
        end

        default: begin
          state   <= IDLE;
          grant_q <= '0;
          en_q    <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.grant   = grant_q;
  assign bus.en      = en_q;
  assign bus.owner   = owner_q;
  assign bus.busy    = busy_q;
  assign bus.timeout = timeout_q;

endmodule

// File: tb/tb_tri_bus_arbiter.sv
// Directed bench for tri_bus_arbiter (N=4, MAX_HOLD=8). Inputs change 1 ns
// after a rising edge and outputs are sampled at that same point, so
// "cycle c" below means the values registered at the c-th edge.
module tb_tri_bus_arbiter;

  localparam int N        = 4;
  localparam int MAX_HOLD = 8;

  logic clk;
  logic rst_n;

  int vectors     = 0;
  int miscompares = 0;

  tri_bus_arbiter_if #(.N(N)) bus ();

  tri_bus_arbiter #(
    .N        (N),
    .MAX_HOLD (MAX_HOLD)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One comparison: counts the vector and reports any mismatch.
  task automatic check(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Grant, enable and busy together.
  task automatic expect_outs(input string tag, input logic [3:0] g,
                             input logic [3:0] e, input logic b);
    check({tag, "_grant"}, bus.grant, g);
    check({tag, "_en"},    bus.en,    e);
    check({tag, "_busy"},  bus.busy,  b);
  endtask

  // Advance one edge; an enable must never sit outside the grant.
  task automatic step();
    @(posedge clk);
    #1;
    check("en_within_grant", bus.en & ~bus.grant, 16'h0);
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    bus.req  = '0;
    bus.done = '0;
    @(posedge clk);
    #1;
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  logic [3:0] oh;

  initial begin
    rst_n    = 1'b0;
    bus.req  = '0;
    bus.done = '0;
    #1;
    expect_outs("reset", 4'b0000, 4'b0000, 1'b0);
    check("reset_owner",   bus.owner,   2'd0);
    check("reset_timeout", bus.timeout, 1'b0);
    do_reset();

    // ---- Single request: req[2], done[2] during cycle 5 ----
    bus.req = 4'b0100;                                  // cycle 0
    step(); expect_outs("single_c1", 4'b0100, 4'b0000, 1'b1);
    check("single_owner", bus.owner, 2'd2);
    step(); expect_outs("single_c2", 4'b0100, 4'b0100, 1'b1);
    step(); expect_outs("single_c3", 4'b0100, 4'b0100, 1'b1);
    step(); expect_outs("single_c4", 4'b0100, 4'b0100, 1'b1);
    step(); expect_outs("single_c5", 4'b0100, 4'b0100, 1'b1);
    bus.done = 4'b0100;
    step(); expect_outs("single_c6", 4'b0000, 4'b0000, 1'b1);
    bus.done = '0;
    bus.req  = '0;
    step(); expect_outs("single_c7", 4'b0000, 4'b0000, 1'b0);
    check("single_owner_hold", bus.owner, 2'd2);

    // ---- Round robin: req=1111 held, done on the 3rd drive cycle ----
    do_reset();
    bus.req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      oh = 4'b0001 << (g % 4);
      step(); expect_outs("rr_grant", oh, 4'b0000, 1'b1);
      check("rr_owner", bus.owner, 16'(g % 4));
      for (int d = 1; d <= 3; d++) begin
        step(); expect_outs("rr_drive", oh, oh, 1'b1);
        if (d == 3) begin
          bus.done = oh;
          if (g == 4) bus.req = '0;
        end
      end
      step(); expect_outs("rr_turn", 4'b0000, 4'b0000, 1'b1);
      check("rr_turn_timeout", bus.timeout, 1'b0);
      bus.done = '0;
    end
    step(); expect_outs("rr_idle", 4'b0000, 4'b0000, 1'b0);

    // ---- Timeout: req[1] alone, then contested by req[3] ----
    bus.req = 4'b0010;                                  // ptr = 1
    step(); expect_outs("to_c1", 4'b0010, 4'b0000, 1'b1);
    for (int c = 2; c <= 9; c++) begin
      step(); expect_outs("to_drive", 4'b0010, 4'b0010, 1'b1);
      check("to_drive_timeout", bus.timeout, 1'b0);
    end
    step(); expect_outs("to_turn", 4'b0000, 4'b0000, 1'b1);
    check("to_pulse", bus.timeout, 1'b1);
    step(); expect_outs("to_regrant_alone", 4'b0010, 4'b0000, 1'b1);
    check("to_pulse_end", bus.timeout, 1'b0);
    bus.req = 4'b1010;
    for (int c = 12; c <= 19; c++) begin
      step(); expect_outs("to2_drive", 4'b0010, 4'b0010, 1'b1);
    end
    step(); check("to2_pulse", bus.timeout, 1'b1);
    step(); expect_outs("to2_next_owner", 4'b1000, 4'b0000, 1'b1);
    check("to2_owner", bus.owner, 2'd3);

    // ---- Abandon in DRIVE (owner 3) then in GRANT (owner 1) ----
    step(); expect_outs("ab_drive", 4'b1000, 4'b1000, 1'b1);
    bus.req = 4'b0010;
    step(); expect_outs("ab_drive_drop", 4'b0000, 4'b0000, 1'b1);
    check("ab_no_timeout", bus.timeout, 1'b0);
    step(); expect_outs("ab_g1", 4'b0010, 4'b0000, 1'b1);
    bus.req = '0;
    step(); expect_outs("ab_g1_turn", 4'b0000, 4'b0000, 1'b1);
    step(); expect_outs("ab_g1_idle", 4'b0000, 4'b0000, 1'b0);
    bus.req = 4'b1000;                                  // ptr = 2
    step(); expect_outs("ab_g3", 4'b1000, 4'b0000, 1'b1);
    bus.req = '0;
    step(); expect_outs("ab_g3_turn", 4'b0000, 4'b0000, 1'b1);
    step(); expect_outs("ab_g3_idle", 4'b0000, 4'b0000, 1'b0);

    // ---- Asynchronous reset mid-DRIVE with en=0010 ----
    bus.req = 4'b0010;                                  // ptr = 0
    step(); expect_outs("rst_g", 4'b0010, 4'b0000, 1'b1);
    step(); expect_outs("rst_d", 4'b0010, 4'b0010, 1'b1);
    #2;
    rst_n   = 1'b0;
    bus.req = 4'b1010;
    #1;
    expect_outs("rst_async", 4'b0000, 4'b0000, 1'b0);
    check("rst_async_owner", bus.owner, 2'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step(); expect_outs("rst_first", 4'b0010, 4'b0000, 1'b1);
    check("rst_first_owner", bus.owner, 2'd1);
    bus.req = '0;
    step(); step();
    expect_outs("rst_idle", 4'b0000, 4'b0000, 1'b0);

    // ---- done meets the hold limit; stray done[0] while 2 owns ----
    bus.req = 4'b0100;                                  // ptr = 2
    step(); expect_outs("co_g", 4'b0100, 4'b0000, 1'b1);
    step(); expect_outs("co_c2", 4'b0100, 4'b0100, 1'b1);
    step();
    bus.done = 4'b0001;
    step(); expect_outs("co_stray", 4'b0100, 4'b0100, 1'b1);
    check("co_stray_owner", bus.owner, 2'd2);
    bus.done = '0;
    for (int c = 5; c <= 9; c++) step();
    expect_outs("co_c9", 4'b0100, 4'b0100, 1'b1);
    bus.done = 4'b0100;
    step(); expect_outs("co_turn", 4'b0000, 4'b0000, 1'b1);
    check("co_no_timeout", bus.timeout, 1'b0);
    bus.done = '0;
    bus.req  = '0;
    step(); expect_outs("co_idle", 4'b0000, 4'b0000, 1'b0);
    check("co_idle_timeout", bus.timeout, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/tri_bus_arbiter.md
# tri_bus_arbiter

Round-robin arbiter and sequencer for a shared tristate/wired-logic bus net. It serves up to N requesters whose drivers sit on one net, each driver being conditionally driven or high-Z under its own enable. The block grants the net to one requester at a time and drives that requester's enable. Between owners it inserts guaranteed all-off cycles so no two enables ever overlap. It sits beside the bus net and owns every driver enable on it.

## Interface
- N, default 4: number of requesters/drivers (2..16).
- MAX_HOLD, default 8: maximum consecutive DRIVE cycles per grant (1..255).
- IW, default $clog2(N): width of owner index.

- clk  in  1  single clock, all state on rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- req  in  N  request per driver, level; hold high until done or release.
- done  in  N  per-driver release pulse; only done[owner] is honoured.
- grant  out  N  one-hot, owner selected (GRANT and DRIVE states).
- en  out  N  one-hot driver enable to the bus drivers (DRIVE state only).
- owner  out  IW  index of current/last owner.
- busy  out  1  high in GRANT, DRIVE, TURN.
- timeout  out  1  one-cycle pulse when a grant was force-ended by MAX_HOLD.

## Operation
- All outputs registered. Reset values: grant=0, en=0, owner=0, busy=0, timeout=0. Reset also sets state=IDLE, ptr=0, hold count=0.
- States: IDLE, GRANT, DRIVE, TURN.
- Arbitration: search req starting at index ptr, then upward modulo N. The first set bit wins (k). On winning, ptr <= (k+1) mod N.
- IDLE: if req != 0, go to GRANT with grant[k]=1, owner=k, en=0. Otherwise stay in IDLE.
- GRANT (1 cycle, setup): if req[k] is still high, go to DRIVE, set en[k]=1 and count=1. If req[k] has dropped, go to TURN without driving.
- DRIVE: exit to TURN on the first of these conditions:
  - done[k]=1 (normal release);
  - req[k]=0 (abandon);
  - count==MAX_HOLD with neither of the above (forced release; timeout=1 during the TURN cycle).
  - Otherwise count increments and the state stays in DRIVE.
  - If done and the MAX_HOLD limit coincide, done wins and no timeout pulse is generated.
- TURN (1 cycle): grant=0 and en=0. Arbitrate as in IDLE. Go directly to GRANT if any req is set, else go to IDLE.
- done from non-owners, and done outside DRIVE, are ignored.
- en is never non-zero outside DRIVE and is always one-hot or zero. grant and en never name different indices.
- Fairness: a requester that keeps req high after release is skipped in favour of any other pending requester, because ptr has advanced past it.
- Async reset in any state clears en within reset assertion, independent of clk, and returns the block to IDLE.

## Timing
- Request seen in IDLE at edge t: grant at t+1, en at t+2. Request-to-drive latency is 2 cycles.
- Release seen at edge e: en and grant drop at e+1 (TURN). The earliest next en is at e+3 (TURN, then GRANT, then DRIVE).
- The minimum all-off gap between two enable windows is 2 cycles (TURN + GRANT).
- Maximum en window is MAX_HOLD cycles. The worst-case wait for any requester is (N-1)·(MAX_HOLD+2) cycles after its req rises with arbitration pending.
- owner holds its value through TURN and IDLE until the next grant.

## Test plan
- Single request, N=4, MAX_HOLD=8: req[2] high at cycle 0, done[2] pulsed at cycle 5.
  - Expect grant=0100 at cycle 1, en=0100 for cycles 2–5, all zero at cycle 6, busy falls at cycle 7.
- Simultaneous req=1111 held, done pulsed on the 3rd DRIVE cycle of every grant.
  - Expect grant order 0,1,2,3,0.
  - Expect en windows of 3 cycles separated by exactly 2 all-zero cycles, with no en overlap.
- Timeout: req[1] held with no done, MAX_HOLD=8.
  - Expect en[1] high exactly 8 cycles, then timeout=1 for one cycle in TURN, then re-grant to 1 only if no other req is pending.
- Abandon: req[3] dropped in GRANT, no en pulse. req[3] dropped in DRIVE, en drops the next cycle and timeout stays 0.
- Reset mid-DRIVE: rst_n low asynchronously while en=0010.
  - Expect en=0, grant=0, busy=0 immediately. After release, the first grant goes from ptr=0.
- Done and limit coinciding on cycle MAX_HOLD: normal release, timeout stays 0. A stray done[0] while 2 owns the bus has no effect.
